// File: rtl/hs_ram_port.sv
// Hiscore-side port for the CPU work RAM: hands the single-port RAM to the hiscore engine while the CPU is paused.
// Optional HS_RAM_PORT_STATS_EN adds dropped-write and grant counters.
`timescale 1ns/1ps
module hs_ram_port #(
    parameter int AW           = 10,
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic          master_clock,
    input  logic          RESET_n,
    input  logic          pause,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic          hs_access_read,
    input  logic          hs_access_write,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_owner,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
`ifdef HS_RAM_PORT_STATS_EN
    ,
    output logic [7:0]    hs_drop_cnt,
    output logic [7:0]    hs_grant_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_DRAIN,
        ST_HS,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t        state_reg;
    logic [3:0]    drain_cnt_reg;
    logic [3:0]    drain_cnt_next;
    logic          hs_owner_reg;
    logic          prev_hs_reg;
    logic [DW-1:0] hs_data_out_reg;
    logic          grant_req;
    logic          drain_done;

    assign grant_req = pause & (hs_access_read | hs_access_write);

    // Any CPU select restarts the idle window so a grant never cuts into a live CPU access.
    assign drain_cnt_next = cpu_cs ? DRAIN_LOAD : 4'(drain_cnt_reg - 4'd1);
    assign drain_done     = (state_reg == ST_DRAIN) && grant_req && (drain_cnt_next == 4'd0);

    always_ff @(posedge master_clock or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg       <= ST_CPU;
            drain_cnt_reg   <= 4'd0;
            hs_owner_reg    <= 1'b0;
            prev_hs_reg     <= 1'b0;
            hs_data_out_reg <= '0;
        end else begin
            prev_hs_reg <= (state_reg == ST_HS);
            if (prev_hs_reg) begin
                hs_data_out_reg <= ram_q;
            end
            case (state_reg)
                ST_CPU: begin
                    if (grant_req) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_next;
                    if (!grant_req) begin
                        state_reg <= ST_CPU;
                    end else if (drain_done) begin
                        state_reg    <= ST_HS;
                        hs_owner_reg <= 1'b1;
                    end
                end
                ST_HS: begin
                    if (!grant_req) begin
                        state_reg    <= ST_RELEASE;
                        hs_owner_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_CPU;
                    hs_owner_reg <= 1'b0;
                end
            endcase
        end
    end

    // Write enable is gated by reset so an interrupted hiscore write never reaches the RAM.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        case (state_reg)
            ST_CPU, ST_DRAIN: ram_we = cpu_cs & cpu_we;
            ST_HS: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write;
            end
            default: ram_we = 1'b0;
        endcase
        if (!RESET_n) begin
            ram_we = 1'b0;
        end
    end

    assign cpu_dout    = ram_q;
    assign hs_data_out = hs_data_out_reg;
    assign hs_owner    = hs_owner_reg;

`ifdef HS_RAM_PORT_STATS_EN
    logic [7:0] hs_drop_cnt_reg;
    logic [7:0] hs_grant_cnt_reg;

    always_ff @(posedge master_clock or negedge RESET_n) begin
        if (!RESET_n) begin
            hs_drop_cnt_reg  <= 8'd0;
            hs_grant_cnt_reg <= 8'd0;
        end else begin
            if (hs_write && (state_reg != ST_HS) && (hs_drop_cnt_reg != 8'hFF)) begin
                hs_drop_cnt_reg <= hs_drop_cnt_reg + 8'd1;
            end
            if (drain_done) begin
                hs_grant_cnt_reg <= hs_grant_cnt_reg + 8'd1;
            end
        end
    end

    assign hs_drop_cnt  = hs_drop_cnt_reg;
    assign hs_grant_cnt = hs_grant_cnt_reg;
`endif

endmodule

// File: tb/tb_hs_ram_port.sv
// Bench for hs_ram_port: CPU-side vector table, grant timing, hiscore read/write sessions, async reset, drop counting.
`timescale 1ns/1ps
module tb_hs_ram_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause, cpu_cs, cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_din, cpu_dout;
    logic       hs_rd, hs_wr;
    logic [9:0] hs_address;
    logic [7:0] hs_data_in, hs_data_out;
    logic       hs_write, hs_owner;
    logic [9:0] ram_addr;
    logic [7:0] ram_din, ram_q;
    logic       ram_we;
`ifdef HS_RAM_PORT_STATS_EN
    logic [7:0] hs_drop_cnt, hs_grant_cnt;
`endif

    always #5 clk = ~clk;

    hs_ram_port #(.AW(10), .DW(8), .DRAIN_CYCLES(2)) dut (
        .master_clock    (clk),
        .RESET_n         (rst_n),
        .pause           (pause),
        .cpu_cs          (cpu_cs),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .hs_access_read  (hs_rd),
        .hs_access_write (hs_wr),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write        (hs_write),
        .hs_data_out     (hs_data_out),
        .hs_owner        (hs_owner),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_we          (ram_we),
        .ram_q           (ram_q)
`ifdef HS_RAM_PORT_STATS_EN
        ,
        .hs_drop_cnt     (hs_drop_cnt),
        .hs_grant_cnt    (hs_grant_cnt)
`endif
    );

    // Single-port synchronous RAM, read-before-write.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         due;
        logic [7:0] exp;
        logic [9:0] addr;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic       cs;
        logic       we;
        logic [9:0] addr;
        logic [7:0] din;
        logic       hsw;
        logic       exp_we;
    } vec_t;
    vec_t vecs [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        sb_t e;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("hs_read_data", hs_data_out, e.exp);
            $display("hs read result addr=%03h data=%02h", e.addr, hs_data_out);
        end
    endtask

    task automatic hs_op(input logic [9:0] a, input logic w, input logic [7:0] d,
                         input logic push, input logic [7:0] exp);
        hs_address = a;
        hs_write   = w;
        hs_data_in = d;
        if (push) sb_q.push_back('{cyc + 2, exp, a});
        sample();
        chk("hs_owner_in_hs", hs_owner, 1);
        chk("hs_ram_we", ram_we, w);
        chk("hs_ram_addr", ram_addr, a);
        if (w) chk("hs_ram_din", ram_din, d);
        $display("hs %s addr=%03h data=%02h", w ? "wr" : "rd", a, w ? d : exp);
        tick();
    endtask

    task automatic wait_grant(input int pulse_at, input logic drv_hsw, input int exp_k, input string nm);
        int got = -1;
        pause      = 1'b1;
        hs_rd      = 1'b1;
        cpu_we     = 1'b0;
        hs_write   = drv_hsw;
        hs_address = 10'h200;
        hs_data_in = 8'h99;
        for (int k = 0; k < 20 && got < 0; k++) begin
            cpu_cs = (k == pulse_at);
            sample();
            if (hs_owner) begin
                got      = k;
                hs_write = 1'b0;
            end else begin
                chk("drain_ram_we", ram_we, 0);
            end
            tick();
        end
        cpu_cs = 1'b0;
        chk(nm, got, exp_k);
        $display("grant %s at cycle %0d", nm, got);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 10'h03A, 8'h5C, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 10'h000, 8'hA0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 10'h001, 8'hA1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 10'h3FF, 8'hEE, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 10'h03A, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'h155, 8'h12, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 10'h2AA, 8'h34, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 10'h100, 8'h66, 1'b0, 1'b1};

        // Reset: write enable forced low even with a CPU write pending.
        rst_n = 1'b0; pause = 1'b0; cpu_cs = 1'b1; cpu_we = 1'b1;
        cpu_addr = 10'h000; cpu_din = 8'h00;
        hs_rd = 1'b0; hs_wr = 1'b0; hs_address = 10'h000; hs_data_in = 8'h00; hs_write = 1'b0;
        repeat (3) @(posedge clk);
        sample();
        chk("reset_hs_owner", hs_owner, 0);
        chk("reset_hs_data_out", hs_data_out, 0);
        chk("reset_ram_we", ram_we, 0);
        tick();
        rst_n = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0;
        hs_rd = 1'b1;

        // CPU-owned phase: intent without pause must never grant.
        for (int i = 0; i < 8; i++) begin
            cpu_cs = vecs[i].cs; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_din = vecs[i].din; hs_write = vecs[i].hsw;
            sample();
            chk("cpu_ram_we", ram_we, vecs[i].exp_we);
            chk("cpu_ram_addr", ram_addr, vecs[i].addr);
            chk("cpu_ram_din", ram_din, vecs[i].din);
            chk("cpu_hs_owner", hs_owner, 0);
            $display("cpu vec %0d cs=%0b we=%0b addr=%03h din=%02h ram_we=%0b", i,
                     vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].din, ram_we);
            tick();
        end
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h03A; hs_write = 1'b0;
        tick();
        cpu_cs = 1'b0;
        sample();
        chk("cpu_dout", cpu_dout, 8'h5C);
        tick();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_hs_owner", hs_owner, 0);
            tick();
        end

        // Session 1: clean grant, reads, back-to-back writes, exit on intent drop.
        wait_grant(-1, 1'b0, 3, "grant_no_cs");
        hs_op(10'h03A, 1'b0, 8'h00, 1'b1, 8'h5C);
        hs_op(10'h000, 1'b0, 8'h00, 1'b1, 8'hA0);
        hs_op(10'h001, 1'b0, 8'h00, 1'b1, 8'hA1);
        hs_op(10'h3FD, 1'b1, 8'h11, 1'b0, 8'h00);
        hs_op(10'h3FE, 1'b1, 8'h22, 1'b0, 8'h00);
        hs_rd = 1'b0;
        hs_op(10'h3FF, 1'b1, 8'h33, 1'b1, 8'hEE);

        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h100; cpu_din = 8'h77; hs_write = 1'b1;
        sample();
        chk("release_hs_owner", hs_owner, 0);
        chk("release_ram_we", ram_we, 0);
        chk("release_ram_addr", ram_addr, 10'h100);
        tick();
        sample();
        chk("after_release_ram_we", ram_we, 1);
        chk("after_release_ram_addr", ram_addr, 10'h100);
        hs_write = 1'b0;
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        sample();
        chk("hold_hs_data_out", hs_data_out, 8'hEE);
        tick();

        // Session 2: CPU select in the drain window delays the grant; early hs_write dropped.
        wait_grant(1, 1'b1, 4, "grant_cs_reload");
`ifdef HS_RAM_PORT_STATS_EN
        chk("grant_cnt", hs_grant_cnt, 2);
`endif
        hs_op(10'h3FD, 1'b0, 8'h00, 1'b1, 8'h11);
        hs_op(10'h3FE, 1'b0, 8'h00, 1'b1, 8'h22);
        hs_op(10'h3FF, 1'b0, 8'h00, 1'b1, 8'h33);
        hs_op(10'h100, 1'b0, 8'h00, 1'b1, 8'h77);
        hs_op(10'h000, 1'b0, 8'h00, 1'b0, 8'h00);
        hs_op(10'h000, 1'b0, 8'h00, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a hiscore write.
        hs_address = 10'h2AA; hs_data_in = 8'hC3; hs_write = 1'b1;
        sample();
        chk("pre_reset_ram_we", ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ram_we", ram_we, 0);
        chk("async_reset_hs_owner", hs_owner, 0);
        chk("async_reset_hs_data_out", hs_data_out, 0);
        hs_write = 1'b0; pause = 1'b0; hs_rd = 1'b0;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h123; cpu_din = 8'h45;
        tick();
        rst_n = 1'b1;
        sample();
        chk("post_reset_hs_owner", hs_owner, 0);
        chk("post_reset_ram_we", ram_we, 1);
        chk("post_reset_ram_addr", ram_addr, 10'h123);
`ifdef HS_RAM_PORT_STATS_EN
        chk("post_reset_drop_cnt", hs_drop_cnt, 0);
        chk("post_reset_grant_cnt", hs_grant_cnt, 0);
`endif
        tick();

        // hs_write outside HS with the CPU idle: never a RAM write.
        cpu_cs = 1'b0; cpu_we = 1'b0; hs_write = 1'b1;
        sample();
        chk("drop_ram_we", ram_we, 0);
        tick();
`ifdef HS_RAM_PORT_STATS_EN
        chk("drop_cnt_one", hs_drop_cnt, 1);
        for (int i = 1; i < 300; i++) begin
            sample();
            if (ram_we !== 1'b0) chk("drop_loop_ram_we", ram_we, 0);
            tick();
        end
        hs_write = 1'b0;
        sample();
        chk("drop_cnt_saturated", hs_drop_cnt, 8'hFF);
        tick();
`else
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("drop_loop_ram_we", ram_we, 0);
            tick();
        end
        hs_write = 1'b0;
`endif

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            sample();
            tick();
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hs_ram_port.md
Name: hs_ram_port

Overview:
- Core-side responder for the hiscore RAM interface: hs_address, hs_data_in, hs_data_out, hs_write, plus the read/write intent strobes.
- Instantiated inside exidy2 in front of the 1 KB CPU work RAM, which is single-port synchronous.
- Muxes that RAM between the game CPU and the hiscore engine. Ownership moves to the hiscore side only while the CPU is paused and its bus has drained.
- Returns hiscore read data with a fixed latency.

Parameters:
AW, 10, RAM/hiscore address width
DW, 8, data width
DRAIN_CYCLES, 2, consecutive idle CPU-bus cycles required before handover (1..15)

Ports:
master_clock  in  1  core clock (45 MHz domain)
RESET_n  in  1  asynchronous active-low reset
pause  in  1  CPU pause (pause_cpu), high = CPU halted
cpu_cs  in  1  CPU RAM select
cpu_we  in  1  CPU write enable (qualified by cpu_cs)
cpu_addr  in  AW  CPU address
cpu_din  in  DW  CPU write data
cpu_dout  out  DW  RAM read data to CPU
hs_access_read  in  1  hiscore read intent
hs_access_write  in  1  hiscore write intent
hs_address  in  AW  hiscore address
hs_data_in  in  DW  hiscore write data
hs_write  in  1  hiscore write strobe, one RAM write per high cycle
hs_data_out  out  DW  hiscore read data
hs_owner  out  1  high while the hiscore side owns the RAM
ram_addr  out  AW  to RAM
ram_din  out  DW  to RAM
ram_we  out  1  to RAM
ram_q  in  DW  RAM data, one cycle after ram_addr

Behaviour:
- Reset is asynchronous and active-low (RESET_n).
- Reset values:
  - state = CPU
  - hs_owner = 0
  - hs_data_out = 0
  - drain counter = 0
  - while RESET_n is low, ram_we is forced to 0
- Asserting reset mid-transfer returns to CPU immediately. No partial write is issued.
- intent = hs_access_read | hs_access_write.
- State CPU:
  - Mux selects the CPU: ram_addr = cpu_addr, ram_din = cpu_din, ram_we = cpu_cs & cpu_we.
  - If pause & intent: go to DRAIN and load the counter with DRAIN_CYCLES.
- State DRAIN:
  - Mux stays on the CPU side.
  - Each cycle: if cpu_cs = 1, reload the counter; otherwise decrement it.
  - Counter reaching 0 with pause & intent still true: go to HS.
  - Pause or intent dropping: go back to CPU.
- State HS:
  - hs_owner = 1.
  - Mux selects hiscore: ram_addr = hs_address, ram_din = hs_data_in, ram_we = hs_write.
  - CPU writes are blocked (ram_we never driven from cpu_we).
  - Pause dropping or intent dropping: go to RELEASE.
- State RELEASE:
  - Lasts exactly one cycle, with ram_we = 0, hs_owner = 0 and the mux on the CPU side.
  - Then go to CPU.
- Registered-output timing:
  - hs_owner is registered and follows the state (asserted from the first HS cycle).
  - The mux and ram_we are combinational from the state register.
- Read latency:
  - hs_data_out <= ram_q every cycle in which the previous cycle was HS.
  - Otherwise hs_data_out holds its value.
  - Result: data for an hs_address presented in HS cycle N is on hs_data_out at cycle N+2, and is held until the next HS read.
- cpu_dout = ram_q (combinational pass-through).
- Writes are back-to-back capable: hs_write high for k consecutive HS cycles gives k RAM writes at successive addresses as presented.
- hs_write asserted outside HS is dropped with no RAM write, including in the cycle of a transition into HS. The state is registered, so the first usable write cycle is the first cycle with hs_owner = 1.
- If pause and intent rise in the same cycle, the entry into DRAIN still applies.
- If pause falls in the same cycle as hs_write in HS, that write is executed (the state is still HS), then the block moves to RELEASE.
- The address is AW bits wide and is not range-checked. It wraps naturally modulo 2^AW.

Optional Feature:
- Macro: HS_RAM_PORT_STATS_EN.
- When defined:
  - Adds output port hs_drop_cnt [7:0].
  - The counter increments on every hs_write cycle that occurs outside HS.
  - It saturates at 255 and is cleared by RESET_n.
  - Adds output hs_grant_cnt [7:0], which increments on each DRAIN->HS transition, wraps modulo 256, and is also cleared by RESET_n.
- When not defined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset released, pause=0, intent=1 for 20 cycles -> state stays CPU, hs_owner=0, ram_we only follows cpu_cs&cpu_we.
- pause=1, intent=1, cpu_cs=0 from cycle 0, DRAIN_CYCLES=2 -> hs_owner rises at cycle 3.
- Same setup, but cpu_cs pulses at cycle 1 -> the grant is delayed by a counter reload.
- In HS, preload RAM[0x3A]=0x5C, present hs_address=0x3A at cycle N -> hs_data_out=0x5C at N+2.
- Back-to-back reads 0x000, 0x001 -> values appear at N+2 and N+3.
- In HS, hs_write=1 for 3 cycles, addresses 0x3FD..0x3FF, data 0x11/0x22/0x33 -> three RAM writes with exact contents.
- Drop intent -> one RELEASE cycle with ram_we=0, then CPU.
- hs_write=1 in CPU state with cpu_cs=0 -> no ram_we. With the macro defined, hs_drop_cnt goes 0->1.
- 300 such drops -> hs_drop_cnt=255.
- In HS, assert RESET_n=0 asynchronously while hs_write=1 -> ram_we=0 immediately, hs_owner=0, hs_data_out=0, state CPU after release.
